// File: rtl/uart_hex_scan_display.sv
// Shows the last NUM_BYTES received UART bytes as hex digits on a multiplexed 7-segment display.
// Optional build macro UART_HEX_LEADING_BLANK_EN blanks both digits of slots that have not been written.
module uart_hex_scan_display #(
  parameter int NUM_BYTES      = 2,
  parameter int REFRESH_CLKS   = 1200,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_RX_DV,
  input  logic [7:0]             i_RX_Byte,
  input  logic                   i_Clear,
  output logic [6:0]             o_Segment,
  output logic [2*NUM_BYTES-1:0] o_Digit_Sel,
  output logic [2:0]             o_Byte_Count
);

  localparam int DIGITS = 2 * NUM_BYTES;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(REFRESH_CLKS);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_TERM  = CNT_W'(REFRESH_CLKS - 1);
  localparam logic [2:0]       COUNT_MAX = 3'(NUM_BYTES);
  localparam logic [6:0]       SEG_UNLIT = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Active-high glyphs, bit 0 = segment A ... bit 6 = segment G.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_glyph = 7'h3F;
      4'h1:    hex_glyph = 7'h06;
      4'h2:    hex_glyph = 7'h5B;
      4'h3:    hex_glyph = 7'h4F;
      4'h4:    hex_glyph = 7'h66;
      4'h5:    hex_glyph = 7'h6D;
      4'h6:    hex_glyph = 7'h7D;
      4'h7:    hex_glyph = 7'h07;
      4'h8:    hex_glyph = 7'h7F;
      4'h9:    hex_glyph = 7'h6F;
      4'hA:    hex_glyph = 7'h77;
      4'hB:    hex_glyph = 7'h7C;
      4'hC:    hex_glyph = 7'h39;
      4'hD:    hex_glyph = 7'h5E;
      4'hE:    hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // i_RX_DV is a one-cycle strobe with no back-pressure: every strobe is
  // accepted in that same cycle unless i_Rst or i_Clear is also high.
  logic [7:0]       slot_q [NUM_BYTES];
  logic [2:0]       count_q;
  logic [CNT_W-1:0] refresh_cnt_q;
  logic [IDX_W-1:0] digit_idx_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      for (int k = 0; k < NUM_BYTES; k++) slot_q[k] <= 8'h00;
      count_q <= 3'd0;
    end else if (i_RX_DV) begin
      slot_q[0] <= i_RX_Byte;
      for (int k = 1; k < NUM_BYTES; k++) slot_q[k] <= slot_q[k-1];
      if (count_q != COUNT_MAX) count_q <= count_q + 3'd1;
    end
  end

`ifdef UART_HEX_LEADING_BLANK_EN
  logic [NUM_BYTES-1:0] written_q;
  logic [DIGITS-1:0]    digit_written;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      written_q <= '0;
    end else if (i_RX_DV) begin
      written_q[0] <= 1'b1;
      for (int k = 1; k < NUM_BYTES; k++) written_q[k] <= written_q[k-1];
    end
  end

  always_comb begin
    digit_written = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      digit_written[2*k]   = written_q[k];
      digit_written[2*k+1] = written_q[k];
    end
  end
`endif

  // Refresh timing is never touched by i_Clear, only by reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= '0;
    end else if (refresh_cnt_q == CNT_TERM) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    end else begin
      refresh_cnt_q <= refresh_cnt_q + CNT_W'(1);
    end
  end

  // Digit 2k is the low nibble of slot k, digit 2k+1 the high nibble.
  logic [3:0] digit_nib [DIGITS];
  logic [6:0] glyph;
  logic [6:0] seg_next;

  always_comb begin
    for (int k = 0; k < NUM_BYTES; k++) begin
      digit_nib[2*k]   = slot_q[k][3:0];
      digit_nib[2*k+1] = slot_q[k][7:4];
    end
  end

  always_comb begin
    glyph = hex_glyph(digit_nib[digit_idx_q]);
`ifdef UART_HEX_LEADING_BLANK_EN
    if (!digit_written[digit_idx_q]) glyph = 7'h00;
`endif
    seg_next = (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Digit_Sel <= '0;
      o_Segment   <= SEG_UNLIT;
    end else begin
      o_Digit_Sel <= DIGITS'(1) << digit_idx_q;
      o_Segment   <= seg_next;
    end
  end

  assign o_Byte_Count = count_q;

endmodule

// File: tb/tb_uart_hex_scan_display.sv
// Scoreboard bench for uart_hex_scan_display: one active-low and one active-high instance share stimulus.
module tb_uart_hex_scan_display;

  localparam int NB = 2;
  localparam int R  = 4;
  localparam int D  = 2 * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rx_dv, clear;
  logic [7:0]   rx_byte;
  logic [6:0]   seg_lo, seg_hi;
  logic [D-1:0] sel_lo, sel_hi;
  logic [2:0]   cnt_lo, cnt_hi;

  uart_hex_scan_display #(.NUM_BYTES(NB), .REFRESH_CLKS(R), .SEG_ACTIVE_LOW(1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_Clear(clear),
    .o_Segment(seg_lo), .o_Digit_Sel(sel_lo), .o_Byte_Count(cnt_lo)
  );

  uart_hex_scan_display #(.NUM_BYTES(NB), .REFRESH_CLKS(R), .SEG_ACTIVE_LOW(0)) dut_hi (
    .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_Clear(clear),
    .o_Segment(seg_hi), .o_Digit_Sel(sel_hi), .o_Byte_Count(cnt_hi)
  );

  int errors = 0;
  int checks = 0;
  logic [13:0] exp_q[$];

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: received bytes, written flags, count, edges since reset release.
  logic [7:0]    m_buf [NB];
  logic [NB-1:0] m_wr;
  int            m_cnt;
  int            edges = 0;

  always @(posedge clk) edges <= rst ? 0 : edges + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [D-1:0] onehot(input int d);
    logic [D-1:0] one;
    one = 1;
    return one << d;
  endfunction

  function automatic logic [D-1:0] exp_sel();
    if (edges == 0) return '0;
    return onehot(((edges - 1) / R) % D);
  endfunction

  function automatic logic [6:0] exp_seg(input int d, input bit active_low);
    logic [7:0] b;
    logic [3:0] nib;
    logic [6:0] g;
    b   = m_buf[d / 2];
    nib = (d % 2 == 1) ? b[7:4] : b[3:0];
    g   = glyph_tab[nib];
`ifdef UART_HEX_LEADING_BLANK_EN
    if (!m_wr[d / 2]) g = 7'h00;
`endif
    return active_low ? ~g : g;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NB; k++) m_buf[k] = 8'h00;
    m_wr  = '0;
    m_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    clear   = clr;
    @(negedge clk);
    rx_dv = 1'b0;
    clear = 1'b0;
    if (clr) begin
      model_clear();
    end else begin
      for (int k = NB - 1; k > 0; k--) begin
        m_buf[k] = m_buf[k-1];
        m_wr[k]  = m_wr[k-1];
      end
      m_buf[0] = b;
      m_wr[0]  = 1'b1;
      if (m_cnt < NB) m_cnt++;
    end
  endtask

  // Queue the expected glyph pair for every digit, then pop one as each digit comes up.
  task automatic check_scan(input string tag);
    logic [13:0] e;
    int waited;
    for (int d = 0; d < D; d++) exp_q.push_back({exp_seg(d, 1'b1), exp_seg(d, 1'b0)});
    for (int d = 0; d < D; d++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (sel_lo !== onehot(d) && waited < 40);
      check_val({tag, "_wait"}, 32'(sel_lo), 32'(onehot(d)));
      e = exp_q.pop_front();
      check_val({tag, "_seg_lo"}, 32'(seg_lo), 32'(e[13:7]));
      check_val({tag, "_seg_hi"}, 32'(seg_hi), 32'(e[6:0]));
      check_val({tag, "_phase"}, 32'(sel_hi), 32'(exp_sel()));
    end
    check_val({tag, "_count"}, 32'(cnt_lo), 32'(m_cnt));
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; clear = 1'b0; rx_byte = 8'h00;
    model_clear();

    repeat (3) @(negedge clk);
    check_val("rst_sel", 32'(sel_lo), 32'h0);
    check_val("rst_seg_lo", 32'(seg_lo), 32'h7F);
    check_val("rst_seg_hi", 32'(seg_hi), 32'h00);
    check_val("rst_count", 32'(cnt_lo), 32'h0);

    // Each digit held R clocks, starting with digit 0 on the first edge after release.
    rst = 1'b0;
    for (int n = 1; n <= D * R + 1; n++) exp_q.push_back(14'(onehot(((n - 1) / R) % D)));
    for (int n = 1; n <= D * R + 1; n++) begin
      @(negedge clk);
      check_val("scan_sel", 32'(sel_lo), 32'(exp_q.pop_front()));
    end

    send_byte(8'hA5, 1'b0);
    check_scan("byte_a5");

    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check_val("count_two", 32'(cnt_lo), 32'd2);
    send_byte(8'h56, 1'b0);
    check_scan("shift_sat");

    send_byte(8'hFF, 1'b1);
    check_val("clr_count", 32'(cnt_hi), 32'd0);
    check_val("clr_phase", 32'(sel_lo), 32'(exp_sel()));
    check_scan("clear_dv");

    send_byte(8'h08, 1'b0);
    check_scan("polarity");

    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      check_scan("random");
    end

    repeat ($urandom_range(1, 9)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    check_val("mid_rst_sel", 32'(sel_lo), 32'h0);
    check_val("mid_rst_seg", 32'(seg_lo), 32'h7F);
    check_val("mid_rst_count", 32'(cnt_lo), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_first", 32'(sel_lo), 32'(onehot(0)));
    check_scan("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
